// File: rtl/ofifo_drain.sv
// Moves rows from an output FIFO into psum memory, one row per WAIT/CAPTURE/WRITE pass.
// The start request latches a base address and a row count; done pulses once the last row is written.
module ofifo_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     num_rows,
  input  logic                   o_valid,
  input  logic [psum_bw*col-1:0] ofifo_out,
  output logic                   rd_ofifo,
  output logic                   mem_cen,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [psum_bw*col-1:0] mem_d,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [addr_bw-1:0]     addr_q, addr_d;
  logic [addr_bw-1:0]     cnt_q, cnt_d;
  logic [psum_bw*col-1:0] data_q, data_d;
  logic [addr_bw-1:0]     last_addr_q, last_addr_d;

  // State and datapath registers; reset clears everything to idle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= {addr_bw{1'b0}};
      cnt_q       <= {addr_bw{1'b0}};
      data_q      <= {(psum_bw*col){1'b0}};
      last_addr_q <= {addr_bw{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      last_addr_q <= last_addr_d;
    end
  end

  // data_q only changes on capture, so it already holds the last written row outside WRITE.
  assign mem_d = data_q;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    last_addr_d = last_addr_q;
    rd_ofifo    = 1'b0;
    mem_cen     = 1'b1;
    mem_wen     = 1'b1;
    mem_addr    = last_addr_q;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_rows != {addr_bw{1'b0}}) begin
            addr_d  = base_addr;
            cnt_d   = num_rows;
            state_d = S_WAIT;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        rd_ofifo = o_valid;
        if (o_valid) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CAPTURE: begin
        data_d  = ofifo_out;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_cen     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = addr_q;
        // Remember the written address so mem_addr holds it once addr_q moves on.
        last_addr_d = addr_q;
        addr_d      = addr_q + addr_bw'(1);
        cnt_d       = cnt_q - addr_bw'(1);
        if (cnt_q == addr_bw'(1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed self-checking bench for ofifo_drain: per-scenario tasks log writes,
// done pulses and reads cycle by cycle, then compare against hand-derived values.
module tb_ofifo_drain;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;

  logic               clk;
  logic               reset;
  logic               start;
  logic [ABW-1:0]     base_addr;
  logic [ABW-1:0]     num_rows;
  logic               o_valid;
  logic [PBW*COL-1:0] ofifo_out;
  logic               rd_ofifo;
  logic               mem_cen;
  logic               mem_wen;
  logic [ABW-1:0]     mem_addr;
  logic [PBW*COL-1:0] mem_d;
  logic               busy;
  logic               done;

  int pass_cnt;
  int total_cnt;

  int             cyc;
  int             wr_cnt;
  logic [ABW-1:0] wr_addr [16];
  logic [127:0]   wr_data [16];
  int             wr_cyc  [16];
  int             done_cnt;
  int             done_cyc;
  int             busy_cnt;
  int             rd_cnt;
  int             row_idx;
  int             row0;

  ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .o_valid   (o_valid),
    .ofifo_out (ofifo_out),
    .rd_ofifo  (rd_ofifo),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_d     (mem_d),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF ^ {8{kk}};
  endfunction

  task automatic clear_log();
    cyc      = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    rd_cnt   = 0;
    row0     = row_idx;
  endtask

  // Observe one cycle's outputs, advance one clock, feed the row the DUT just read.
  task automatic tick();
    logic rd_now;
    if (!mem_cen && !mem_wen && wr_cnt < 16) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_d;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    rd_now = rd_ofifo;
    if (rd_now) rd_cnt++;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
    if (rd_now) begin
      ofifo_out = pat(row_idx);
      row_idx++;
    end
  endtask

  task automatic kick(input logic [ABW-1:0] b, input logic [ABW-1:0] n);
    clear_log();
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    o_valid = 1'b1;
    start   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (rd_ofifo !== 1'b0) $display("FAIL reset_rd: got %b want 0", rd_ofifo); else pass_cnt++;
    total_cnt++;
    if (mem_cen !== 1'b1 || mem_wen !== 1'b1) $display("FAIL reset_cen_wen: got %b%b want 11", mem_cen, mem_wen); else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 11'h000 || mem_d !== 128'h0) $display("FAIL reset_mem: got %h/%h want 0/0", mem_addr, mem_d); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done); else pass_cnt++;
    total_cnt++;
    start = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    o_valid = 1'b1;
    kick(11'h010, 11'd3);
    repeat (13) tick();
    if (wr_cnt !== 3) $display("FAIL basic_nwr: got %0d want 3", wr_cnt); else pass_cnt++;
    total_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (wr_addr[i] !== 11'h010 + 11'(i) || wr_cyc[i] !== 3 * (i + 1))
        $display("FAIL basic_wr%0d: got addr %h cyc %0d want %h cyc %0d", i, wr_addr[i], wr_cyc[i], 11'h010 + 11'(i), 3 * (i + 1));
      else pass_cnt++;
      total_cnt++;
      if (wr_data[i] !== pat(row0 + i)) $display("FAIL basic_data%0d: got %h want %h", i, wr_data[i], pat(row0 + i)); else pass_cnt++;
      total_cnt++;
    end
    if (done_cnt !== 1 || done_cyc !== 10) $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=10", done_cnt, done_cyc); else pass_cnt++;
    total_cnt++;
    if (rd_cnt !== 3) $display("FAIL basic_rd: got %0d want 3", rd_cnt); else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 11'h012 || mem_d !== pat(row0 + 2) || mem_cen !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_hold: got addr %h cen %b busy %b want 012 1 0", mem_addr, mem_cen, busy);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_zero_rows();
    o_valid = 1'b1;
    kick(11'h123, 11'd0);
    repeat (4) tick();
    if (done_cnt !== 1 || done_cyc !== 1) $display("FAIL zero_done: got n=%0d cyc=%0d want n=1 cyc=1", done_cnt, done_cyc); else pass_cnt++;
    total_cnt++;
    if (busy_cnt !== 1) $display("FAIL zero_busy: got %0d want 1", busy_cnt); else pass_cnt++;
    total_cnt++;
    if (rd_cnt !== 0 || wr_cnt !== 0) $display("FAIL zero_noop: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stall();
    kick(11'h100, 11'd2);
    for (int c = 0; c < 15; c++) begin
      o_valid = !(c >= 4 && c <= 8);
      tick();
    end
    o_valid = 1'b1;
    if (wr_cnt !== 2 || wr_cyc[0] !== 3 || wr_cyc[1] !== 11)
      $display("FAIL stall_wr: got n=%0d cyc %0d,%0d want 2 at 3,11", wr_cnt, wr_cyc[0], wr_cyc[1]);
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt !== 2) $display("FAIL stall_rd: got %0d want 2", rd_cnt); else pass_cnt++;
    total_cnt++;
    if (done_cyc !== 12 || wr_addr[1] !== 11'h101) $display("FAIL stall_done: got cyc %0d addr %h want 12 101", done_cyc, wr_addr[1]); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_wrap();
    o_valid = 1'b1;
    kick(11'h7FF, 11'd2);
    repeat (9) tick();
    if (wr_cnt !== 2 || wr_addr[0] !== 11'h7FF || wr_addr[1] !== 11'h000)
      $display("FAIL wrap_addr: got n=%0d %h,%h want 2 7ff,000", wr_cnt, wr_addr[0], wr_addr[1]);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_start_ignored();
    o_valid = 1'b1;
    kick(11'h020, 11'd4);
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        start     = 1'b1;
        base_addr = 11'h300;
        num_rows  = 11'd7;
      end
      tick();
    end
    if (wr_cnt !== 4 || wr_addr[3] !== 11'h023 || done_cnt !== 1)
      $display("FAIL ign_start: got n=%0d last %h done %0d want 4 023 1", wr_cnt, wr_addr[3], done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (wr_data[3] !== pat(row0 + 3) || busy !== 1'b0) $display("FAIL ign_tail: got %h busy %b want %h 0", wr_data[3], busy, pat(row0 + 3)); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_reset_mid();
    o_valid = 1'b1;
    kick(11'h040, 11'd3);
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    if (busy !== 1'b0 || rd_ofifo !== 1'b0 || mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 11'h000 || mem_d !== 128'h0)
      $display("FAIL rstmid_async: got busy %b rd %b cen %b addr %h want 0 0 1 000", busy, rd_ofifo, mem_cen, mem_addr);
    else pass_cnt++;
    total_cnt++;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    if (wr_cnt !== 1 || done_cnt !== 0) $display("FAIL rstmid_abandon: got wr=%0d done=%0d want 1 0", wr_cnt, done_cnt); else pass_cnt++;
    total_cnt++;
    kick(11'h055, 11'd1);
    repeat (7) tick();
    if (wr_cnt !== 1 || wr_addr[0] !== 11'h055 || wr_cyc[0] !== 3 || wr_data[0] !== pat(row0))
      $display("FAIL rstmid_restart: got n=%0d addr %h cyc %0d want 1 055 3", wr_cnt, wr_addr[0], wr_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1 || done_cyc !== 4) $display("FAIL rstmid_done: got n=%0d cyc %0d want 1 4", done_cnt, done_cyc); else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    row_idx   = 1;
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = 11'h000;
    num_rows  = 11'd0;
    o_valid   = 1'b0;
    ofifo_out = 128'h0;
    clear_log();
    test_reset();
    test_basic();
    test_zero_rows();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
